// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions: FSM state encoding, exponent constants, bf16 field layout.
// Used by the int16 converter and the bf16 adder.
package bf16_pkg;

    localparam int         BF16_BIAS      = 127;
    // Exponent of bit 15 of a 16-bit magnitude before normalisation
    localparam logic [7:0] INT16_EXP_BASE = 8'(BF16_BIAS + 15);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        NORMALIZE,
        ROUND,
        FINISH
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exponent;
        logic [6:0] mantissa;
    } bf16_t;

    // Unsigned magnitude of a two's-complement int16; -32768 maps to 0x8000
    function automatic logic [15:0] int16_magnitude(input logic [15:0] value);
        return value[15] ? (~value + 16'd1) : value;
    endfunction

endpackage

// File: rtl/bf16_round.sv
// Rounds a normalised bf16 mantissa using guard/sticky; carries mantissa overflow into the exponent.
// Latency: combinational. Backpressure: none.
// BF16_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncates.
module bf16_round (
    input  logic [6:0] mant_in,
    input  logic [7:0] exp_in,
    input  logic       guard,
    input  logic       sticky,
    output logic [6:0] mant_out,
    output logic [7:0] exp_out,
    output logic       inexact
);

    logic round_up;
    logic carry;

`ifdef BF16_ROUND_NEAREST_EN
    // Ties go to the even mantissa
    assign round_up = guard & (sticky | mant_in[0]);
`else
    assign round_up = 1'b0;
`endif

    assign {carry, mant_out} = {1'b0, mant_in} + {7'd0, round_up};
    assign exp_out           = exp_in + {7'd0, carry};
    assign inexact           = guard | sticky;

endmodule

// File: rtl/int16_to_bfloat16.sv
// Converts a two's-complement int16 to bfloat16, normalising one bit per cycle.
// Latency: lz+4 cycles (nonzero), 2 cycles (zero). Backpressure: start accepted only while ready; result held until next done.
// Rounding mode set in bf16_round by BF16_ROUND_NEAREST_EN (truncate when undefined).
module int16_to_bfloat16
    import bf16_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] result,
    output logic        ready,
    output logic        done,
    output logic        inexact
);

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [15:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    bf16_t       result_q, result_d;
    logic        inexact_q, inexact_d;

    logic [6:0]  rnd_mant;
    logic [7:0]  rnd_exp;
    logic        rnd_inexact;

    bf16_round u_round (
        .mant_in  (mag_q[14:8]),
        .exp_in   (exp_q),
        .guard    (mag_q[7]),
        .sticky   (|mag_q[6:0]),
        .mant_out (rnd_mant),
        .exp_out  (rnd_exp),
        .inexact  (rnd_inexact)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sign_q    <= 1'b0;
            mag_q     <= '0;
            exp_q     <= '0;
            result_q  <= '0;
            inexact_q <= 1'b0;
        end else begin
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            result_q  <= result_d;
            inexact_q <= inexact_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        result_d  = result_q;
        inexact_d = inexact_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d  = data_in[15];
                    mag_d   = int16_magnitude(data_in);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                exp_d = INT16_EXP_BASE;
                if (mag_q == 16'd0) begin
                    result_d  = '0;
                    inexact_d = 1'b0;
                    state_d   = FINISH;
                end else begin
                    state_d = NORMALIZE;
                end
            end
            NORMALIZE: begin
                if (mag_q[15]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[14:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            ROUND: begin
                // Leading one of mag_q is the implicit bit and is dropped
                result_d.sign     = sign_q;
                result_d.exponent = rnd_exp;
                result_d.mantissa = rnd_mant;
                inexact_d         = rnd_inexact;
                state_d           = FINISH;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result  = result_q;
    assign inexact = inexact_q;
    assign ready   = (state_q == IDLE);
    assign done    = (state_q == FINISH);

endmodule
